traffic_ctrl_n: RTL and testbench
=================================

Name: traffic_ctrl_n

Overview:
- Parametrised N-approach traffic-light controller. Successor to the fixed two-way green/yellow/red controller with blink mode.
- Serves NUM_DIR approaches round-robin: green, then yellow, then an all-red clearance per approach, each with a configurable duration.
- A mode input switches every approach to blinking yellow.
- Sits between the tick/clock domain of the intersection board and the lamp drivers. Lamp outputs are Moore, decoded from state only.

Parameters:
- NUM_DIR, 2, number of approaches (2..8).
- T_GREEN, 4, green duration in clock cycles (>=1).
- T_YELLOW, 1, yellow duration in cycles (>=1).
- T_ALLRED, 1, all-red clearance duration in cycles (>=1).
- T_BLINK, 1, duration of each blink half-period (on or off) in cycles (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- modo  in  1  0 = normal cycling, 1 = blink mode; sampled every cycle.
- demand  in  NUM_DIR  per-approach vehicle request; used only with DEMAND_SKIP_EN.
- green  out  NUM_DIR  green lamp per approach.
- yellow  out  NUM_DIR  yellow lamp per approach.
- red  out  NUM_DIR  red lamp per approach.
- cur_dir  out  $clog2(NUM_DIR)  index of the approach currently served.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset (port reset) is asynchronous and active-high.
  - On reset: state = GREEN, cur_dir = 0, timer = 0.
  - During and after reset: green[0]=1, red[others]=1, all other lamps 0.
- States: GREEN, YELLOW, ALLRED, BLINK_ON, BLINK_OFF.
- Timer:
  - Width $clog2(max(T_GREEN,T_YELLOW,T_ALLRED,T_BLINK)+1).
  - Clears to 0 on every state change (including cur_dir change) and increments otherwise.
  - A state with duration T is held for exactly T cycles: it exits when timer == T-1.
- Normal transitions (modo=0):
  - GREEN -> YELLOW -> ALLRED -> GREEN(next_dir).
  - next_dir = (cur_dir+1) mod NUM_DIR, unless DEMAND_SKIP_EN is defined.
  - cur_dir updates on the ALLRED->GREEN edge only.
- Blink entry:
  - modo=1 in GREEN, YELLOW or ALLRED -> BLINK_ON next cycle, regardless of timer.
  - cur_dir holds its value.
- Blink toggle: with modo=1, BLINK_ON <-> BLINK_OFF every T_BLINK cycles.
- Blink exit: modo=0 in BLINK_ON or BLINK_OFF -> GREEN next cycle with cur_dir = 0 and timer = 0.
- Precedence: a mode change in the same cycle as timer expiry wins; the normal transition is discarded.
- Lamp decode, in GREEN and YELLOW (for cur_dir = i):
  - GREEN: green[i]=1; red=1 on all j != i.
  - YELLOW: yellow[i]=1; red=1 on all j != i.
- Lamp decode, other states:
  - ALLRED: red all 1.
  - BLINK_ON: yellow all 1, red and green 0.
  - BLINK_OFF: all lamps 0.
- Invariant: at most one approach is non-red outside blink states. Each approach asserts at most one lamp at any time.
- Reset mid-cycle: immediate return to the reset state. No partial timer carries over.
- Parameter errors: NUM_DIR<2 or any T*<1 is an elaboration error (generate-time $error).

Optional Feature:
- DEMAND_SKIP_EN defined:
  - demand is sampled in the final ALLRED cycle.
  - next_dir = first j in the order cur_dir+1, ..., cur_dir+NUM_DIR (mod N, the current approach checked last) with demand[j]=1.
  - If demand is all zero, next_dir = (cur_dir+1) mod N.
  - Blink exit still goes to approach 0.
- Not defined: demand is ignored (port kept, unconnected internally) and the sequence is strict round-robin.

Test Plan:
- Defaults (NUM_DIR=2), modo=0, release reset at cycle 0 -> dir0 green cycles 0-3, yellow 4, all-red 5, dir1 green 6-9, yellow 10, all-red 11, dir0 green 12; period = 12 cycles.
- modo=1 asserted during dir1 green, 2nd cycle -> next cycle all yellow=1 (BLINK_ON). With T_BLINK=2: yellow on 2 cycles, off 2 cycles, repeating. cur_dir stays 1.
- modo=0 during BLINK_OFF -> next cycle green[0]=1, red[1]=1, cur_dir=0; full 4-cycle green follows.
- modo=1 in the exact cycle GREEN timer hits T_GREEN-1 -> BLINK_ON, never YELLOW.
- Async reset pulsed mid-YELLOW (between edges) -> outputs return immediately to green[0]=1, red[1]=1, with no clock edge needed.
- NUM_DIR=4, DEMAND_SKIP_EN, demand=4'b1000 while serving dir0 -> after ALLRED, cur_dir=3. Then demand=0 -> next dir 0 (3+1 mod 4). demand=4'b0001 while serving dir0 -> dir0 served again.

Source files
------------

// File: rtl/traffic_ctrl_n.sv
// rtl/traffic_ctrl_n.sv - N-approach round-robin traffic-light controller with blink mode
//
// Purpose: serves NUM_DIR approaches in turn (green -> yellow -> all-red
// clearance) and switches every approach to blinking yellow while modo=1.
// Lamp outputs are Moore, decoded from state and cur_dir only.
//
// Optional build macro: DEMAND_SKIP_EN -- when defined, the next approach is
// the first one (after the current, current last) with demand asserted in the
// final all-red cycle; otherwise demand is ignored and order is round-robin.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset    in   asynchronous active-high reset
//   modo     in   0 = normal cycling, 1 = blink mode
//   demand   in   [NUM_DIR] per-approach request (DEMAND_SKIP_EN only)
//   green    out  [NUM_DIR] green lamps
//   yellow   out  [NUM_DIR] yellow lamps
//   red      out  [NUM_DIR] red lamps
//   cur_dir  out  [$clog2(NUM_DIR)] approach currently served

module traffic_ctrl_n #(
  parameter int NUM_DIR  = 2,
  parameter int T_GREEN  = 4,
  parameter int T_YELLOW = 1,
  parameter int T_ALLRED = 1,
  parameter int T_BLINK  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       modo,
  input  logic [NUM_DIR-1:0]         demand,
  output logic [NUM_DIR-1:0]         green,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         red,
  output logic [$clog2(NUM_DIR)-1:0] cur_dir
);

  localparam int DIR_W = $clog2(NUM_DIR);
  localparam int T_GY  = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int T_AB  = (T_ALLRED > T_BLINK) ? T_ALLRED : T_BLINK;
  localparam int T_MAX = (T_GY > T_AB) ? T_GY : T_AB;
  localparam int TMR_W = $clog2(T_MAX + 1);

  // Terminal timer values: a state of duration T exits when timer == T-1.
  localparam logic [TMR_W-1:0] G_LAST = TMR_W'(T_GREEN - 1);
  localparam logic [TMR_W-1:0] Y_LAST = TMR_W'(T_YELLOW - 1);
  localparam logic [TMR_W-1:0] A_LAST = TMR_W'(T_ALLRED - 1);
  localparam logic [TMR_W-1:0] B_LAST = TMR_W'(T_BLINK - 1);
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(NUM_DIR - 1);

  if (NUM_DIR < 2 || T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_BLINK < 1) begin : g_param_check
    $error("traffic_ctrl_n: NUM_DIR must be >= 2 and every duration >= 1");
  end

  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_BLINK_ON,
    S_BLINK_OFF
  } state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [DIR_W-1:0]   dir_n;
  logic [DIR_W-1:0]   rr_next;
  logic [DIR_W-1:0]   next_dir;
  logic [NUM_DIR-1:0] dir_onehot;

  // Wrap explicitly so non-power-of-two NUM_DIR never reaches an unused index.
  assign rr_next = (cur_dir == DIR_LAST) ? '0 : cur_dir + DIR_W'(1);

`ifdef DEMAND_SKIP_EN
  logic [DIR_W-1:0] cand;
  logic [DIR_W-1:0] skip_next;
  logic             found;

  // Walk cur_dir+1 .. cur_dir+NUM_DIR; the current approach is visited last.
  always_comb begin
    cand      = cur_dir;
    skip_next = rr_next;
    found     = 1'b0;
    for (int k = 0; k < NUM_DIR; k++) begin
      cand = (cand == DIR_LAST) ? '0 : cand + DIR_W'(1);
      if (!found && demand[cand]) begin
        skip_next = cand;
        found     = 1'b1;
      end
    end
  end

  assign next_dir = skip_next;
`else
  logic unused_demand;

  assign unused_demand = ^demand;
  assign next_dir      = rr_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_GREEN;
      cur_dir <= '0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      cur_dir <= dir_n;
      timer   <= timer_n;
    end
  end

  // Mode changes are tested before timer expiry so they win on a tie.
  always_comb begin
    state_n = state;
    dir_n   = cur_dir;
    timer_n = timer + TMR_W'(1);
    case (state)
      S_GREEN: begin
        if (modo) begin
          state_n = S_BLINK_ON;
          timer_n = '0;
        end else if (timer == G_LAST) begin
          state_n = S_YELLOW;
          timer_n = '0;
        end
      end
      S_YELLOW: begin
        if (modo) begin
          state_n = S_BLINK_ON;
          timer_n = '0;
        end else if (timer == Y_LAST) begin
          state_n = S_ALLRED;
          timer_n = '0;
        end
      end
      S_ALLRED: begin
        if (modo) begin
          state_n = S_BLINK_ON;
          timer_n = '0;
        end else if (timer == A_LAST) begin
          state_n = S_GREEN;
          dir_n   = next_dir;
          timer_n = '0;
        end
      end
      S_BLINK_ON: begin
        if (!modo) begin
          state_n = S_GREEN;
          dir_n   = '0;
          timer_n = '0;
        end else if (timer == B_LAST) begin
          state_n = S_BLINK_OFF;
          timer_n = '0;
        end
      end
      S_BLINK_OFF: begin
        if (!modo) begin
          state_n = S_GREEN;
          dir_n   = '0;
          timer_n = '0;
        end else if (timer == B_LAST) begin
          state_n = S_BLINK_ON;
          timer_n = '0;
        end
      end
      default: begin
        state_n = S_GREEN;
        dir_n   = '0;
        timer_n = '0;
      end
    endcase
  end

  assign dir_onehot = NUM_DIR'(1) << cur_dir;

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '0;
    case (state)
      S_GREEN: begin
        green = dir_onehot;
        red   = ~dir_onehot;
      end
      S_YELLOW: begin
        yellow = dir_onehot;
        red    = ~dir_onehot;
      end
      S_ALLRED: begin
        red = '1;
      end
      S_BLINK_ON: begin
        yellow = '1;
      end
      default: begin
        green  = '0;
        yellow = '0;
        red    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// tb/tb_traffic_ctrl_n.sv - self-checking bench for traffic_ctrl_n

module tb_traffic_ctrl_n;

  localparam int NA = 2, GA = 4, YA = 1, AA = 1, BA = 2;
  localparam int NB = 4, GB = 3, YB = 2, AB = 2, BB = 1;
`ifdef DEMAND_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          modo;
  logic [NA-1:0] demand_a;
  logic [NB-1:0] demand_b;
  logic [NA-1:0] green_a, yellow_a, red_a;
  logic [NB-1:0] green_b, yellow_b, red_b;
  logic [0:0]    cur_dir_a;
  logic [1:0]    cur_dir_b;
  logic [31:0]   obs_a, obs_b;

  traffic_ctrl_n #(.NUM_DIR(NA), .T_GREEN(GA), .T_YELLOW(YA), .T_ALLRED(AA), .T_BLINK(BA)) dut_a (
    .clk(clk), .reset(reset), .modo(modo), .demand(demand_a),
    .green(green_a), .yellow(yellow_a), .red(red_a), .cur_dir(cur_dir_a)
  );

  traffic_ctrl_n #(.NUM_DIR(NB), .T_GREEN(GB), .T_YELLOW(YB), .T_ALLRED(AB), .T_BLINK(BB)) dut_b (
    .clk(clk), .reset(reset), .modo(modo), .demand(demand_b),
    .green(green_b), .yellow(yellow_b), .red(red_b), .cur_dir(cur_dir_b)
  );

  assign obs_a = {8'(green_a), 8'(yellow_a), 8'(red_a), 8'(cur_dir_a)};
  assign obs_b = {8'(green_b), 8'(yellow_b), 8'(red_b), 8'(cur_dir_b)};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0/1/2 = green/yellow/all-red, left = cycles remaining in the phase.
  typedef struct packed {
    bit blink;
    bit lit;
    int phase;
    int left;
    int dir;
  } mstate_t;

  mstate_t ma, mb;
  int      checks;
  int      errors;
  int      cyc;

  function automatic mstate_t model_reset(int tg);
    mstate_t s;
    s.blink = 1'b0;
    s.lit   = 1'b0;
    s.phase = 0;
    s.left  = tg;
    s.dir   = 0;
    return s;
  endfunction

  function automatic int model_next_dir(int d, int n, logic [7:0] dem);
    if (SKIP_EN) begin
      for (int k = 1; k <= n; k++) begin
        if (dem[(d + k) % n]) return (d + k) % n;
      end
    end
    return (d + 1) % n;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int n, int tg, int ty, int ta, int tb,
                                         bit mv, logic [7:0] dem);
    mstate_t r;
    r = s;
    if (!s.blink) begin
      if (mv) begin
        r.blink = 1'b1;
        r.lit   = 1'b1;
        r.left  = tb;
      end else begin
        r.left = s.left - 1;
        if (r.left == 0) begin
          if (s.phase == 0) begin
            r.phase = 1;
            r.left  = ty;
          end else if (s.phase == 1) begin
            r.phase = 2;
            r.left  = ta;
          end else begin
            r.phase = 0;
            r.left  = tg;
            r.dir   = model_next_dir(s.dir, n, dem);
          end
        end
      end
    end else begin
      if (!mv) begin
        r = model_reset(tg);
      end else begin
        r.left = s.left - 1;
        if (r.left == 0) begin
          r.lit  = !s.lit;
          r.left = tb;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] expect_vec(mstate_t s, int n);
    logic [7:0] mask, one, g, y, r;
    mask = 8'((1 << n) - 1);
    one  = 8'(1 << s.dir);
    g = 8'h00;
    y = 8'h00;
    r = 8'h00;
    if (s.blink) begin
      if (s.lit) y = mask;
    end else if (s.phase == 0) begin
      g = one;
      r = mask & ~one;
    end else if (s.phase == 1) begin
      y = one;
      r = mask & ~one;
    end else begin
      r = mask;
    end
    return {g, y, r, 8'(s.dir)};
  endfunction

  // Default-parameter two-way sequence: 12-cycle period, 6 cycles per approach.
  function automatic logic [31:0] table_vec(int c_abs);
    int c, d, p;
    logic [7:0] one, g, y, r;
    c = c_abs % 12;
    d = c / 6;
    p = c % 6;
    one = 8'(1 << d);
    g = (p < 4) ? one : 8'h00;
    y = (p == 4) ? one : 8'h00;
    r = (p == 5) ? 8'h03 : (8'h03 & ~one);
    return {g, y, r, 8'(d)};
  endfunction

  task automatic advance();
    @(posedge clk);
    ma = model_step(ma, NA, GA, YA, AA, BA, modo, 8'(demand_a));
    mb = model_step(mb, NB, GB, YB, AB, BB, modo, 8'(demand_b));
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 32'h0100_0200) begin
      errors++;
      $display("FAIL reset_hold_a got=%h exp=%h", obs_a, 32'h0100_0200);
    end
    checks++;
    if (obs_b !== 32'h0100_0e00) begin
      errors++;
      $display("FAIL reset_hold_b got=%h exp=%h", obs_b, 32'h0100_0e00);
    end
    reset = 1'b0;
    ma = model_reset(GA);
    mb = model_reset(GB);
    cyc = 0;
    #1;
    checks++;
    if (obs_a !== expect_vec(ma, NA)) begin
      errors++;
      $display("FAIL reset_release_a got=%h exp=%h", obs_a, expect_vec(ma, NA));
    end
  endtask

  task automatic test_normal_cycle();
    modo = 1'b0;
    for (int i = 0; i < 24; i++) begin
      demand_b = 4'($urandom);
      advance();
      checks++;
      if (obs_a !== table_vec(cyc)) begin
        errors++;
        $display("FAIL normal_table_a cyc=%0d got=%h exp=%h", cyc, obs_a, table_vec(cyc));
      end
      checks++;
      if (obs_b !== expect_vec(mb, NB)) begin
        errors++;
        $display("FAIL normal_b cyc=%0d got=%h exp=%h", cyc, obs_b, expect_vec(mb, NB));
      end
    end
  endtask

  task automatic test_blink();
    // cycle 24 is period start; cycle 31 is the 2nd green cycle of approach 1
    repeat (7) advance();
    modo = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [1:0] exp_y;
      advance();
      exp_y = ((k / 2) % 2 == 0) ? 2'b11 : 2'b00;
      checks++;
      if (yellow_a !== exp_y || green_a !== 2'b00 || red_a !== 2'b00 || cur_dir_a !== 1'b1) begin
        errors++;
        $display("FAIL blink_toggle_a k=%0d got_y=%b g=%b r=%b dir=%0d exp_y=%b dir=1",
                 k, yellow_a, green_a, red_a, cur_dir_a, exp_y);
      end
      checks++;
      if (obs_b !== expect_vec(mb, NB)) begin
        errors++;
        $display("FAIL blink_b k=%0d got=%h exp=%h", k, obs_b, expect_vec(mb, NB));
      end
    end
  endtask

  task automatic test_blink_exit();
    int n;
    n = 0;
    while (!(ma.blink && !ma.lit) && n < 10) begin
      advance();
      n++;
      checks++;
      if (obs_a !== expect_vec(ma, NA)) begin
        errors++;
        $display("FAIL blink_wait_a cyc=%0d got=%h exp=%h", cyc, obs_a, expect_vec(ma, NA));
      end
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL blink_off_timeout got=%0d cycles exp=<10", n);
    end
    modo = 1'b0;
    for (int j = 0; j <= GA; j++) begin
      logic [31:0] exp_v;
      advance();
      exp_v = (j < GA) ? 32'h0100_0200 : 32'h0001_0200;
      checks++;
      if (obs_a !== exp_v) begin
        errors++;
        $display("FAIL blink_exit_a j=%0d got=%h exp=%h", j, obs_a, exp_v);
      end
      checks++;
      if (obs_b !== expect_vec(mb, NB)) begin
        errors++;
        $display("FAIL blink_exit_b j=%0d got=%h exp=%h", j, obs_b, expect_vec(mb, NB));
      end
    end
  endtask

  task automatic test_mode_at_expiry();
    int n;
    n = 0;
    while (!(!ma.blink && ma.phase == 0 && ma.left == 1) && n < 20) begin
      advance();
      n++;
      checks++;
      if (obs_a !== expect_vec(ma, NA)) begin
        errors++;
        $display("FAIL expiry_wait_a cyc=%0d got=%h exp=%h", cyc, obs_a, expect_vec(ma, NA));
      end
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL expiry_timeout got=%0d cycles exp=<20", n);
    end
    modo = 1'b1;
    advance();
    checks++;
    if (yellow_a !== 2'b11 || green_a !== 2'b00 || red_a !== 2'b00) begin
      errors++;
      $display("FAIL mode_wins_expiry got_g=%b y=%b r=%b exp_g=00 y=11 r=00", green_a, yellow_a, red_a);
    end
    checks++;
    if (obs_b !== expect_vec(mb, NB)) begin
      errors++;
      $display("FAIL expiry_b got=%h exp=%h", obs_b, expect_vec(mb, NB));
    end
    modo = 1'b0;
    advance();
    checks++;
    if (obs_a !== 32'h0100_0200) begin
      errors++;
      $display("FAIL expiry_exit_a got=%h exp=%h", obs_a, 32'h0100_0200);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    modo = 1'b0;
    while (!(!ma.blink && ma.phase == 1) && n < 20) begin
      advance();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL yellow_wait_timeout got=%0d cycles exp=<20", n);
    end
    checks++;
    if (yellow_a !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_yellow_a got=%b exp=01", yellow_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_a !== 32'h0100_0200) begin
      errors++;
      $display("FAIL async_reset_a got=%h exp=%h", obs_a, 32'h0100_0200);
    end
    checks++;
    if (obs_b !== 32'h0100_0e00) begin
      errors++;
      $display("FAIL async_reset_b got=%h exp=%h", obs_b, 32'h0100_0e00);
    end
    #1 reset = 1'b0;
    ma = model_reset(GA);
    mb = model_reset(GB);
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      advance();
      checks++;
      if (obs_a !== table_vec(cyc)) begin
        errors++;
        $display("FAIL post_reset_a cyc=%0d got=%h exp=%h", cyc, obs_a, table_vec(cyc));
      end
      checks++;
      if (obs_b !== expect_vec(mb, NB)) begin
        errors++;
        $display("FAIL post_reset_b cyc=%0d got=%h exp=%h", cyc, obs_b, expect_vec(mb, NB));
      end
    end
  endtask

  task automatic test_demand();
    modo = 1'b0;
    for (int i = 0; i < 80; i++) begin
      demand_a = 2'($urandom);
      demand_b = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      advance();
      checks++;
      if (obs_a !== expect_vec(ma, NA)) begin
        errors++;
        $display("FAIL demand_a cyc=%0d got=%h exp=%h", cyc, obs_a, expect_vec(ma, NA));
      end
      checks++;
      if (obs_b !== expect_vec(mb, NB)) begin
        errors++;
        $display("FAIL demand_b cyc=%0d got=%h exp=%h", cyc, obs_b, expect_vec(mb, NB));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) modo = !modo;
      demand_a = 2'($urandom);
      demand_b = 4'($urandom);
      advance();
      checks++;
      if (obs_a !== expect_vec(ma, NA)) begin
        errors++;
        $display("FAIL random_a cyc=%0d got=%h exp=%h", cyc, obs_a, expect_vec(ma, NA));
      end
      checks++;
      if (obs_b !== expect_vec(mb, NB)) begin
        errors++;
        $display("FAIL random_b cyc=%0d got=%h exp=%h", cyc, obs_b, expect_vec(mb, NB));
      end
    end
    modo = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    reset    = 1'b1;
    modo     = 1'b0;
    demand_a = '0;
    demand_b = '0;
    ma = model_reset(GA);
    mb = model_reset(GB);
    test_reset();
    test_normal_cycle();
    test_blink();
    test_blink_exit();
    test_mode_at_expiry();
    test_async_reset();
    test_demand();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
